// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell, LSB first.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 result bits are ever read back; the
  // outgoing LSB would be dead, so it is not stored.
  logic [WIDTH-2:0] r_r_sh;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  full_subtractor u_fs (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Bin  (r_brw),
    .D    (w_d),
    .Bout (w_bout)
  );

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_shift  = (r_state == S_SHIFT);
  assign w_last   = w_shift && (r_cnt == LAST);
  assign w_r_next = {w_d, r_r_sh};

  // Next-state decode: IDLE -> SHIFT -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand shifters, borrow recirculation and bit counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_r_sh <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= i_a;
      r_b_sh <= i_b;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_r_sh <= w_r_next[WIDTH-1:1];
      r_brw  <= w_bout;
      // Parked at zero after the last bit so it never wraps.
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Published results, updated only on the completion edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_last) begin
      r_diff   <= w_r_next;
      r_borrow <= w_bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_sign;
  logic r_b_sign;
  logic r_ovf;

  // Operand sign bits captured with the operands.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
    end else if (w_accept) begin
      r_a_sign <= i_a[WIDTH-1];
      r_b_sign <= i_b[WIDTH-1];
    end
  end

  // Overflow: signs differ and result sign differs from minuend.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a_sign ^ r_b_sign) & (w_d ^ r_a_sign);
    end
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_ready  = (r_state == S_IDLE);
  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = (r_state == S_DONE);
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl, WIDTH=8.
// Cycle model plus literal expectations per operation.

module tb_serial_subtractor_ctrl;

  localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_ovf;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_diff   (o_diff),
    .o_borrow (o_borrow),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit sovf(input logic [W-1:0] x,
                              input logic [W-1:0] y);
    int sx;
    int sy;
    int d;
    sx = int'($signed(x));
    sy = int'($signed(y));
    d  = sx - sy;
    return (d > 127) || (d < -128);
  endfunction

  // Model: an accepted op makes done appear W edges later,
  // ready returns one edge after that.
  bit           m_valid = 1'b0;
  bit           m_active = 1'b0;
  int           m_n = 0;
  logic [W-1:0] m_diff, m_pdiff;
  logic         m_borrow, m_pborrow;
  logic         m_ovf, m_povf;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_diff   = '0;
      m_borrow = 1'b0;
      m_ovf    = 1'b0;
    end else if (m_active) begin
      m_n++;
      if (m_n == W) begin
        m_diff   = m_pdiff;
        m_borrow = m_pborrow;
        m_ovf    = m_povf;
      end
      if (m_n == W + 1) m_active = 1'b0;
    end else if (start) begin
      m_active  = 1'b1;
      m_n       = 0;
      m_pdiff   = a - b;
      m_pborrow = (a < b);
      m_povf    = OVF_EN && sovf(a, b);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", o_ready, !m_active);
      check("busy", o_busy, m_active && (m_n < W));
      check("done", o_done, m_active && (m_n == W));
      check("diff", o_diff, m_diff);
      check("borrow", o_borrow, m_borrow);
      check("ovf", o_ovf, m_ovf);
    end
  end

  task automatic wait_done(output int k);
    bit found;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (o_done) begin
        k = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done");
    end
  endtask

  task automatic op(input string nm,
                    input logic [W-1:0] ta,
                    input logic [W-1:0] tb,
                    input logic [W-1:0] ed,
                    input logic eb,
                    input logic eo);
    int k;
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(k);
    check({nm, "_lat"}, k, W);
    check({nm, "_diff"}, o_diff, ed);
    check({nm, "_brw"}, o_borrow, eb);
    check({nm, "_ovf"}, o_ovf, eo);
    @(negedge clk);
  endtask

  initial begin
    int k;
    int k2;
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_diff", o_diff, 8'h00);
    rst_n = 1'b1;

    op("t35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    op("t12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    op("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op("tFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    op("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, OVF_EN);
    op("t7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, OVF_EN);

    // start pulses during SHIFT and DONE are ignored
    @(negedge clk);
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    check("ign_diff", o_diff, 8'h23);
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_ready", o_ready, 1'b1);
    @(negedge clk);
    check("ign_busy", o_busy, 1'b0);

    // start held high: done every W+2 cycles
    a = 8'h40;
    b = 8'h03;
    start = 1'b1;
    wait_done(k);
    wait_done(k2);
    check("held_period", k2, W + 2);
    check("held_diff", o_diff, 8'h3D);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_idle", o_ready, 1'b1);

    // reset on the 4th shift edge aborts the op
    a = 8'h12;
    b = 8'h35;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ab_ready", o_ready, 1'b1);
    check("ab_diff", o_diff, 8'h00);
    check("ab_busy", o_busy, 1'b0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    check("ab_nodone", nd, 0);

    op("post_rst", 8'hC8, 8'h64, 8'h64, 1'b0, OVF_EN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
